reg_read_port: RTL



---
 rtl/reg_read_port.sv | 84 ++++++++
 1 files changed

// File: rtl/reg_read_port.sv
// Two-entry register file with a registered, handshaked read port.
// Same-cycle writes forward into read data; per-register dirty flags track unread writes.
module reg_read_port #(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic                  wr_select,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_req,
  input  logic                  rd_select,
  output logic                  rd_accept,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  rd_ack,
  output logic [1:0]            dirty
);

  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] reg0_q, reg0_d;
  logic [DATA_WIDTH-1:0] reg1_q, reg1_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic [1:0]            dirty_q, dirty_d;
  logic                  forward;

  assign rd_valid  = (state_q == FULL);
  assign rd_data   = rd_data_q;
  assign dirty     = dirty_q;
  assign rd_accept = rd_req & (~rd_valid | rd_ack);
  assign forward   = wr_en & (wr_select == rd_select);

  // Next-state: writes first, then the read accept so its dirty clear wins.
  always_comb begin
    state_d   = state_q;
    reg0_d    = reg0_q;
    reg1_d    = reg1_q;
    rd_data_d = rd_data_q;
    dirty_d   = dirty_q;

    if (wr_en) begin
      if (wr_select) reg1_d = wr_data;
      else           reg0_d = wr_data;
      dirty_d[wr_select] = 1'b1;
    end

    case (state_q)
      EMPTY: begin
        if (rd_accept) state_d = FULL;
      end
      FULL: begin
        if (rd_ack && !rd_accept) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase

    if (rd_accept) begin
      if (forward)        rd_data_d = wr_data;
      else if (rd_select) rd_data_d = reg1_q;
      else                rd_data_d = reg0_q;
      dirty_d[rd_select] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= EMPTY;
      reg0_q    <= '0;
      reg1_q    <= '0;
      rd_data_q <= '0;
      dirty_q   <= 2'b00;
    end else begin
      state_q   <= state_d;
      reg0_q    <= reg0_d;
      reg1_q    <= reg1_d;
      rd_data_q <= rd_data_d;
      dirty_q   <= dirty_d;
    end
  end

endmodule
